// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction-RAM arbiter.
package ram_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/ram_arb_if.sv
// Requester pair plus RAM side of the arbiter; master = requesters/RAM, slave = arbiter.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic [DW-1:0] m0_data;
  logic          m0_valid;
  logic          m0_err;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_gnt;
  logic [DW-1:0] m1_data;
  logic          m1_valid;
  logic          m1_err;

  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic [DW-1:0] ram_data;
  logic          ram_valid;

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, ram_data, ram_valid,
    input  m0_gnt, m0_data, m0_valid, m0_err,
    input  m1_gnt, m1_data, m1_valid, m1_err,
    input  ram_addr, ram_en
  );

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, ram_data, ram_valid,
    output m0_gnt, m0_data, m0_valid, m0_err,
    output m1_gnt, m1_data, m1_valid, m1_err,
    output ram_addr, ram_en
  );

endinterface

// File: rtl/ram_arb_wdog.sv
// WAIT-state watchdog: start reloads and arms, clear disarms, expire flags the TIMEOUT-th cycle.
module ram_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          run;

  // expire is high during the cycle that completes TIMEOUT armed cycles
  assign expire = run && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one instruction RAM between two requesters; RAM_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: gnt/ram_en one cycle after the request is sampled in IDLE; response L+1 cycles after gnt.
// Backpressure: requests held until gnt; the non-owner stays pending while a transaction is in flight.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input logic      clk,
  input logic      rst,
  ram_arb_if.slave bus
);

  state_t        state;
  logic          owner;
  logic          rr_ptr;
  logic          pick;
  logic          expire;
  logic [AW-1:0] addr_r;
  logic          en_r;
  logic          gnt0_r, gnt1_r;
  logic          vld0_r, vld1_r;
  logic          err0_r, err1_r;
  logic [DW-1:0] dat0_r, dat1_r;

  always_comb begin
    pick = PORT0;
    if (bus.m0_req && bus.m1_req) pick = rr_ptr;
    else if (bus.m1_req)          pick = PORT1;
  end

`ifdef RAM_ARB_TIMEOUT_EN
  ram_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .start  (state == ISSUE),
    .clear  ((state == WAIT) && (bus.ram_valid || expire)),
    .expire (expire)
  );
`else
  // WAIT is unbounded; TIMEOUT only matters when the watchdog is built
  assign expire = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= PORT0;
      rr_ptr <= PORT0;
      addr_r <= '0;
      en_r   <= 1'b0;
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      vld0_r <= 1'b0;
      vld1_r <= 1'b0;
      err0_r <= 1'b0;
      err1_r <= 1'b0;
      dat0_r <= '0;
      dat1_r <= '0;
    end else begin
      en_r   <= 1'b0;
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      vld0_r <= 1'b0;
      vld1_r <= 1'b0;
      err0_r <= 1'b0;
      err1_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner  <= pick;
            addr_r <= (pick == PORT1) ? bus.m1_addr : bus.m0_addr;
            gnt0_r <= (pick == PORT0);
            gnt1_r <= (pick == PORT1);
            en_r   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // a real response on the expiry cycle takes precedence over the timeout
          if (bus.ram_valid || expire) begin
            if (owner == PORT0) begin
              vld0_r <= 1'b1;
              err0_r <= !bus.ram_valid;
              dat0_r <= bus.ram_valid ? bus.ram_data : '0;
            end else begin
              vld1_r <= 1'b1;
              err1_r <= !bus.ram_valid;
              dat1_r <= bus.ram_valid ? bus.ram_data : '0;
            end
            rr_ptr <= ~owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt   = gnt0_r;
  assign bus.m0_data  = dat0_r;
  assign bus.m0_valid = vld0_r;
  assign bus.m0_err   = err0_r;
  assign bus.m1_gnt   = gnt1_r;
  assign bus.m1_data  = dat1_r;
  assign bus.m1_valid = vld1_r;
  assign bus.m1_err   = err1_r;
  assign bus.ram_addr = addr_r;
  assign bus.ram_en   = en_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, single/alternating transactions, spurious and late RAM strobes, timeout.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_d0;
  logic [15:0] exp_d1;

  ram_arb_if #(.AW(16), .DW(16)) bus ();

  ram_arbiter #(
    .AW      (16),
    .DW      (16),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":gnt0"}, bus.m0_gnt, 0);
    chk({tag, ":gnt1"}, bus.m1_gnt, 0);
    chk({tag, ":en"}, bus.ram_en, 0);
    chk({tag, ":addr"}, bus.ram_addr, 0);
    chk({tag, ":vld0"}, bus.m0_valid, 0);
    chk({tag, ":vld1"}, bus.m1_valid, 0);
    chk({tag, ":err0"}, bus.m0_err, 0);
    chk({tag, ":err1"}, bus.m1_err, 0);
    chk({tag, ":dat0"}, bus.m0_data, 0);
    chk({tag, ":dat1"}, bus.m1_data, 0);
  endtask

  // Entered in an IDLE cycle with requests already driven; returns in the response cycle.
  task automatic run_xact(input logic port, input logic [15:0] addr, input logic [15:0] data,
                          input int lat, input logic drop, input string tag);
    step();
    chk({tag, ":gnt0"}, bus.m0_gnt, !port);
    chk({tag, ":gnt1"}, bus.m1_gnt, port);
    chk({tag, ":en"}, bus.ram_en, 1);
    chk({tag, ":addr"}, bus.ram_addr, addr);
    step();
    if (drop) begin
      if (port) bus.m1_req = 1'b0;
      else      bus.m0_req = 1'b0;
    end
    chk({tag, ":en_off"}, bus.ram_en, 0);
    chk({tag, ":addr_hold"}, bus.ram_addr, addr);
    for (int i = 1; i < lat; i++) begin
      chk({tag, ":early_vld"}, bus.m0_valid | bus.m1_valid, 0);
      step();
    end
    bus.ram_valid = 1'b1;
    bus.ram_data  = data;
    step();
    bus.ram_valid = 1'b0;
    bus.ram_data  = 16'h0;
    if (port) exp_d1 = data;
    else      exp_d0 = data;
    chk({tag, ":vld0"}, bus.m0_valid, !port);
    chk({tag, ":vld1"}, bus.m1_valid, port);
    chk({tag, ":err0"}, bus.m0_err, 0);
    chk({tag, ":err1"}, bus.m1_err, 0);
    chk({tag, ":dat0"}, bus.m0_data, exp_d0);
    chk({tag, ":dat1"}, bus.m1_data, exp_d1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.m0_req    = 1'b0;
    bus.m0_addr   = 16'h0;
    bus.m1_req    = 1'b0;
    bus.m1_addr   = 16'h0;
    bus.ram_data  = 16'h0;
    bus.ram_valid = 1'b0;
    exp_d0        = 16'h0;
    exp_d1        = 16'h0;

    repeat (3) step();
    chk_zero("reset");

    // first request after reset; requester drops req one cycle after gnt
    rst         = 1'b1;
    bus.m0_req  = 1'b1;
    bus.m0_addr = 16'h0010;
    run_xact(1'b0, 16'h0010, 16'hA5A5, 1, 1'b1, "single");
    step();
    chk("single:vld_pulse", bus.m0_valid, 0);
    chk("single:dat_hold", bus.m0_data, 16'hA5A5);
    chk("single:no_regrant", bus.m0_gnt, 0);

    // spurious strobe in IDLE with nobody requesting
    bus.ram_valid = 1'b1;
    bus.ram_data  = 16'hDEAD;
    step();
    bus.ram_valid = 1'b0;
    chk("spur_idle:vld0", bus.m0_valid, 0);
    chk("spur_idle:vld1", bus.m1_valid, 0);
    chk("spur_idle:en", bus.ram_en, 0);

    // spurious strobe in IDLE (with request) and again in ISSUE
    bus.ram_valid = 1'b1;
    bus.m1_req    = 1'b1;
    bus.m1_addr   = 16'h0100;
    step();
    chk("spur_issue:gnt1", bus.m1_gnt, 1);
    chk("spur_issue:addr", bus.ram_addr, 16'h0100);
    chk("spur_issue:vld", bus.m0_valid | bus.m1_valid, 0);
    step();
    bus.ram_valid = 1'b0;
    bus.m1_req    = 1'b0;
    chk("spur_wait1:vld", bus.m0_valid | bus.m1_valid, 0);
    chk("spur_wait1:en", bus.ram_en, 0);
    step();
    chk("spur_wait2:vld", bus.m0_valid | bus.m1_valid, 0);
    bus.ram_valid = 1'b1;
    bus.ram_data  = 16'h5A5A;
    step();
    bus.ram_valid = 1'b0;
    chk("spur_resp:vld1", bus.m1_valid, 1);
    chk("spur_resp:dat1", bus.m1_data, 16'h5A5A);
    chk("spur_resp:vld0", bus.m0_valid, 0);
    chk("spur_resp:dat0", bus.m0_data, 16'hA5A5);
    exp_d1 = 16'h5A5A;
    step();
    chk("spur_once:vld1", bus.m1_valid, 0);

    // both ports hammering: grants alternate 0,1,0,1
    bus.m0_req  = 1'b1;
    bus.m0_addr = 16'h0001;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 16'h0002;
    run_xact(1'b0, 16'h0001, 16'h1111, 1, 1'b0, "rr_a");
    run_xact(1'b1, 16'h0002, 16'h2222, 2, 1'b0, "rr_b");
    run_xact(1'b0, 16'h0001, 16'h3333, 1, 1'b0, "rr_c");
    run_xact(1'b1, 16'h0002, 16'h4444, 1, 1'b0, "rr_d");
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;

    // reset asserted in WAIT, RAM answers late
    step();
    bus.m1_req  = 1'b1;
    bus.m1_addr = 16'h0200;
    step();
    chk("midrst:gnt1", bus.m1_gnt, 1);
    step();
    rst        = 1'b0;
    bus.m1_req = 1'b0;
    step();
    exp_d0 = 16'h0;
    exp_d1 = 16'h0;
    chk_zero("midrst");
    rst = 1'b1;
    step();
    bus.ram_valid = 1'b1;
    bus.ram_data  = 16'hBAD0;
    step();
    bus.ram_valid = 1'b0;
    chk("late:vld0", bus.m0_valid, 0);
    chk("late:vld1", bus.m1_valid, 0);
    chk("late:gnt", bus.m0_gnt | bus.m1_gnt, 0);

    bus.m1_req  = 1'b1;
    bus.m1_addr = 16'h0300;
    run_xact(1'b1, 16'h0300, 16'hBEEF, 1, 1'b1, "post_rst");
    bus.m0_req  = 1'b1;
    bus.m0_addr = 16'h0400;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 16'h0500;
    run_xact(1'b0, 16'h0400, 16'h0404, 1, 1'b0, "tie");

    // silent RAM on a port-1 transaction
    bus.m0_req  = 1'b0;
    bus.m1_addr = 16'h0600;
    step();
    chk("silent:gnt1", bus.m1_gnt, 1);
    chk("silent:addr", bus.ram_addr, 16'h0600);
    bus.m1_req = 1'b0;
    step();
`ifdef RAM_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to:wait_vld1", bus.m1_valid, 0);
      step();
    end
    exp_d1 = 16'h0;
    chk("to:vld1", bus.m1_valid, 1);
    chk("to:err1", bus.m1_err, 1);
    chk("to:dat1", bus.m1_data, 16'h0);
    chk("to:vld0", bus.m0_valid, 0);
    chk("to:err0", bus.m0_err, 0);
    step();
    chk("to:vld1_pulse", bus.m1_valid, 0);
    chk("to:err1_pulse", bus.m1_err, 0);
    bus.m1_req  = 1'b1;
    bus.m1_addr = 16'h0700;
    run_xact(1'b1, 16'h0700, 16'h7777, 4, 1'b1, "to_race");
`else
    for (int i = 0; i < 10; i++) begin
      chk("nto:wait_vld1", bus.m1_valid, 0);
      chk("nto:wait_err1", bus.m1_err, 0);
      step();
    end
    bus.ram_valid = 1'b1;
    bus.ram_data  = 16'h6666;
    step();
    bus.ram_valid = 1'b0;
    exp_d1 = 16'h6666;
    chk("nto:vld1", bus.m1_valid, 1);
    chk("nto:err1", bus.m1_err, 0);
    chk("nto:dat1", bus.m1_data, 16'h6666);
`endif

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
